// File: rtl/f1_pkg.sv
// rtl/f1_pkg.sv - shared types and constants for the F1 reaction timer
package f1_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        DELAY,
        WAIT_PRESS,
        DONE,
        FAULT
    } state_t;

    localparam int              LFSR_W    = 7;
    localparam logic [LFSR_W-1:0] LFSR_SEED = 7'h01;

    // x^7 + x^6 + 1: feedback taken from bits 6 and 5
    localparam int TAP_HI = 6;
    localparam int TAP_LO = 5;

endpackage

// File: rtl/f1_lfsr.sv
// rtl/f1_lfsr.sv - free-running 7-bit Fibonacci LFSR, never reaches zero
module f1_lfsr
    import f1_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    output logic [LFSR_W-1:0] lfsr
);

    logic [LFSR_W-1:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = {lfsr_q[LFSR_W-2:0], lfsr_q[TAP_HI] ^ lfsr_q[TAP_LO]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign lfsr = lfsr_q;

endmodule

// File: rtl/f1_reaction_timer.sv
// rtl/f1_reaction_timer.sv - random lights-out delay and reaction timing; F1_BEST_TIME_EN keeps best time
module f1_reaction_timer
    import f1_pkg::*;
#(
    parameter int TICK_DIV  = 1000,
    parameter int CNT_W     = 16,
    parameter int MIN_DELAY = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_delay,
    input  logic             button,
    output logic             lights_out,
    output logic [CNT_W-1:0] react_time,
    output logic             valid,
    output logic             false_start,
    output logic             busy,
    output logic [CNT_W-1:0] best_time
);

    localparam int               PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int               DLY_W   = $clog2((1 << LFSR_W) + MIN_DELAY);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t             state_q, state_d;
    logic               cmd_q, cmd_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [DLY_W-1:0]   delay_q, delay_d;
    logic [CNT_W-1:0]   react_cnt_q, react_cnt_d;
    logic [CNT_W-1:0]   react_time_q, react_time_d;
    logic [LFSR_W-1:0]  lfsr;
    logic               start, tick, sat_timeout;

    f1_lfsr u_lfsr (
        .clk   (clk),
        .rst_n (rst),
        .lfsr  (lfsr)
    );

    assign start       = cmd_delay & ~cmd_q;
    assign tick        = (presc_q == PRESC_W'(TICK_DIV - 1));
    assign sat_timeout = (state_q == WAIT_PRESS) && !button && tick && (react_cnt_q == CNT_MAX);

    always_comb begin
        state_d      = state_q;
        cmd_d        = cmd_delay;
        presc_d      = tick ? '0 : presc_q + PRESC_W'(1);
        delay_d      = delay_q;
        react_cnt_d  = react_cnt_q;
        react_time_d = react_time_q;
        case (state_q)
            IDLE: begin
                if (start) state_d = ARM;
            end
            ARM: begin
                delay_d = DLY_W'(lfsr) + DLY_W'(MIN_DELAY);
                presc_d = '0;
                state_d = DELAY;
            end
            DELAY: begin
                // an early press wins over an expiry tick in the same cycle
                if (button) begin
                    state_d = FAULT;
                end else if (tick) begin
                    delay_d = delay_q - DLY_W'(1);
                    if (delay_q == DLY_W'(1)) begin
                        state_d     = WAIT_PRESS;
                        presc_d     = '0;
                        react_cnt_d = '0;
                    end
                end
            end
            WAIT_PRESS: begin
                if (button) begin
                    react_time_d = react_cnt_q;
                    state_d      = DONE;
                end else if (sat_timeout) begin
                    react_time_d = CNT_MAX;
                    state_d      = DONE;
                end else if (tick) begin
                    react_cnt_d = react_cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            FAULT: begin
                if (!button && !cmd_delay) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            cmd_q        <= 1'b0;
            presc_q      <= '0;
            delay_q      <= '0;
            react_cnt_q  <= '0;
            react_time_q <= '0;
        end else begin
            state_q      <= state_d;
            cmd_q        <= cmd_d;
            presc_q      <= presc_d;
            delay_q      <= delay_d;
            react_cnt_q  <= react_cnt_d;
            react_time_q <= react_time_d;
        end
    end

`ifdef F1_BEST_TIME_EN
    logic [CNT_W-1:0] best_q, best_d;
    logic             timeout_q, timeout_d;

    // timeout_q remembers how the last WAIT_PRESS ended, so DONE can skip timeouts
    always_comb begin
        timeout_d = (state_q == WAIT_PRESS) ? sat_timeout : timeout_q;
        best_d    = best_q;
        if ((state_q == DONE) && !timeout_q && (react_time_q < best_q)) begin
            best_d = react_time_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            best_q    <= '1;
            timeout_q <= 1'b0;
        end else begin
            best_q    <= best_d;
            timeout_q <= timeout_d;
        end
    end

    assign best_time = best_q;
`else
    assign best_time = '1;
`endif

    assign lights_out  = (state_q == WAIT_PRESS);
    assign valid       = (state_q == DONE);
    assign false_start = (state_q == FAULT);
    assign busy        = (state_q != IDLE);
    assign react_time  = react_time_q;

endmodule

// File: tb/tb_f1_reaction_timer.sv
// tb/tb_f1_reaction_timer.sv - self-checking bench for f1_reaction_timer, aware of F1_BEST_TIME_EN
module tb_f1_reaction_timer;

    localparam int TICK_DIV  = 4;
    localparam int CNT_W     = 8;
    localparam int MIN_DELAY = 2;
    localparam int P_IDLE = 0, P_ARM = 1, P_DELAY = 2, P_WAIT = 3, P_DONE = 4, P_FAULT = 5;

    logic             clk       = 1'b0;
    logic             rst       = 1'b1;
    logic             cmd_delay = 1'b0;
    logic             button    = 1'b0;
    logic             lights_out, valid, false_start, busy;
    logic [CNT_W-1:0] react_time, best_time;

    int checks = 0;
    int fails  = 0;

    f1_reaction_timer #(
        .TICK_DIV  (TICK_DIV),
        .CNT_W     (CNT_W),
        .MIN_DELAY (MIN_DELAY)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_delay   (cmd_delay),
        .button      (button),
        .lights_out  (lights_out),
        .react_time  (react_time),
        .valid       (valid),
        .false_start (false_start),
        .busy        (busy),
        .best_time   (best_time)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h expected=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference: phases advance on absolute cycle deadlines derived from the LFSR draw.
    int               m_phase     = P_IDLE;
    int               m_cyc       = 0;
    int               m_lights_at = 0;
    logic [6:0]       m_lfsr      = 7'h01;
    logic             m_cmd_prev  = 1'b0;
    logic             m_timeout   = 1'b0;
    logic [CNT_W-1:0] m_react     = '0;
    logic [CNT_W-1:0] m_best      = '1;

    always begin
        @(posedge clk or negedge rst);
        if (!rst) begin
            m_phase    = P_IDLE;
            m_cyc      = 0;
            m_lfsr     = 7'h01;
            m_cmd_prev = 1'b0;
            m_timeout  = 1'b0;
            m_react    = '0;
            m_best     = '1;
        end else begin
            case (m_phase)
                P_IDLE: if (cmd_delay && !m_cmd_prev) m_phase = P_ARM;
                P_ARM: begin
                    m_lights_at = m_cyc + 1 + TICK_DIV * (int'(m_lfsr) + MIN_DELAY);
                    m_phase     = P_DELAY;
                end
                P_DELAY: begin
                    if (button) m_phase = P_FAULT;
                    else if (m_cyc + 1 == m_lights_at) m_phase = P_WAIT;
                end
                P_WAIT: begin
                    if (button) begin
                        m_react   = CNT_W'((m_cyc - m_lights_at) / TICK_DIV);
                        m_timeout = 1'b0;
                        m_phase   = P_DONE;
                    end else if (m_cyc == m_lights_at + TICK_DIV - 1 + TICK_DIV * ((1 << CNT_W) - 1)) begin
                        m_react   = '1;
                        m_timeout = 1'b1;
                        m_phase   = P_DONE;
                    end
                end
                P_DONE: begin
                    if (!m_timeout && m_react < m_best) m_best = m_react;
                    m_phase = P_IDLE;
                end
                P_FAULT: if (!button && !cmd_delay) m_phase = P_IDLE;
                default: m_phase = P_IDLE;
            endcase
            m_cmd_prev = cmd_delay;
            m_lfsr     = {m_lfsr[5:0], m_lfsr[6] ^ m_lfsr[5]};
            m_cyc++;
        end
    end

    function automatic logic [CNT_W-1:0] best_exp(input logic [CNT_W-1:0] v);
`ifdef F1_BEST_TIME_EN
        return v;
`else
        return v | '1;
`endif
    endfunction

    always @(negedge clk) begin
        chk("lights_out", 32'(lights_out), 32'(m_phase == P_WAIT));
        chk("valid", 32'(valid), 32'(m_phase == P_DONE));
        chk("false_start", 32'(false_start), 32'(m_phase == P_FAULT));
        chk("busy", 32'(busy), 32'(m_phase != P_IDLE));
        chk("react_time", 32'(react_time), 32'(m_react));
        chk("best_time", 32'(best_time), 32'(best_exp(m_best)));
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_lights(input int budget);
        int n = 0;
        while (!lights_out && n < budget) begin
            step(1);
            n++;
        end
        if (!lights_out) chk("wait_lights_timeout", 32'(lights_out), 32'd1);
    endtask

    task automatic wait_valid(input int budget);
        int n = 0;
        while (!valid && n < budget) begin
            step(1);
            n++;
        end
        if (!valid) chk("wait_valid_timeout", 32'(valid), 32'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "bench watchdog");
    end

    initial begin
        #2 rst = 1'b0;
        step(3);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_react", 32'(react_time), 32'd0);
        chk("rst_best", 32'(best_time), 32'hFF);
        chk("rst_lights", 32'(lights_out), 32'd0);
        rst = 1'b1;
        step(5);

        // Run A: reaction 5 ticks, with a stray cmd_delay edge during WAIT_PRESS
        cmd_delay = 1'b1;
        step(1);
        wait_lights(700);
        step(3);
        cmd_delay = 1'b0;
        step(3);
        cmd_delay = 1'b1;
        step(15);
        button = 1'b1;
        wait_valid(10);
        chk("runA_react", 32'(react_time), 32'd5);
        chk("runA_valid", 32'(valid), 32'd1);
        step(1);
        chk("runA_lights_drop", 32'(lights_out), 32'd0);
        chk("runA_best", 32'(best_time), 32'(best_exp(8'd5)));
        button = 1'b0;
        cmd_delay = 1'b0;
        step(2);

        // Run B: press 13 cycles after lights out -> 3 ticks
        cmd_delay = 1'b1;
        step(1);
        wait_lights(700);
        step(13);
        button = 1'b1;
        wait_valid(10);
        chk("runB_react", 32'(react_time), 32'd3);
        step(1);
        chk("runB_best", 32'(best_time), 32'(best_exp(8'd3)));
        button = 1'b0;
        cmd_delay = 1'b0;
        step(2);

        // False start
        cmd_delay = 1'b1;
        step(10);
        button = 1'b1;
        step(2);
        chk("fs_flag", 32'(false_start), 32'd1);
        chk("fs_lights", 32'(lights_out), 32'd0);
        step(3);
        button = 1'b0;
        step(2);
        chk("fs_hold_cmd", 32'(false_start), 32'd1);
        cmd_delay = 1'b0;
        step(2);
        chk("fs_clear", 32'(false_start), 32'd0);
        chk("fs_idle", 32'(busy), 32'd0);
        chk("fs_react_kept", 32'(react_time), 32'd3);

        // Timeout
        cmd_delay = 1'b1;
        step(1);
        wait_lights(700);
        wait_valid(1100);
        chk("to_react", 32'(react_time), 32'hFF);
        step(1);
        chk("to_best", 32'(best_time), 32'(best_exp(8'd3)));
        cmd_delay = 1'b0;
        step(2);

        // Run C: reaction 7 ticks, best stays 3; then cmd held high without a new edge
        cmd_delay = 1'b1;
        step(1);
        wait_lights(700);
        step(29);
        button = 1'b1;
        wait_valid(10);
        chk("runC_react", 32'(react_time), 32'd7);
        step(1);
        chk("runC_best", 32'(best_time), 32'(best_exp(8'd3)));
        button = 1'b0;
        step(60);
        chk("held_cmd_no_run", 32'(busy), 32'd0);

        // Async reset in the middle of DELAY
        cmd_delay = 1'b0;
        step(2);
        cmd_delay = 1'b1;
        step(6);
        chk("mid_delay_busy", 32'(busy), 32'd1);
        rst = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_react", 32'(react_time), 32'd0);
        chk("abort_best", 32'(best_time), 32'hFF);
        chk("abort_lights", 32'(lights_out), 32'd0);
        step(1);
        rst = 1'b1;
        cmd_delay = 1'b0;
        step(20);
        chk("post_abort_idle", 32'(busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
